// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers (op, a, b) commands in a small FIFO and issues
// them one at a time to the ALU. Completion is decided per opcode, either after
// a fixed latency or on alu_valid with a timeout guard. Results are returned on
// a valid/ready response port.
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FIXED_LAT = 2,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             alu_start,
  output logic [4:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_valid,
  input  logic             alu_busy,
  input  logic             alu_error,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [4:0]       rsp_op,
  output logic             rsp_error,
  output logic             rsp_timeout
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned LAT_MAX = (TIMEOUT > FIXED_LAT) ? TIMEOUT : FIXED_LAT;
  localparam int unsigned WAIT_W  = $clog2(LAT_MAX + 1);

  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_EXP = 5'b01001;
  localparam logic [4:0] OP_DIV = 5'b01010;
  localparam logic [4:0] OP_MOD = 5'b01011;
  localparam logic [4:0] OP_MAC = 5'b01110;

  typedef struct packed {
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_alu_start;
  logic [4:0]        r_alu_op;
  logic [WIDTH-1:0]  r_alu_a;
  logic [WIDTH-1:0]  r_alu_b;
  logic              r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_result;
  logic [4:0]        r_rsp_op;
  logic              r_rsp_error;
  logic              r_rsp_timeout;

  logic w_push;
  logic w_pop;
  logic w_multi;
  logic w_mac_clr;
  cmd_t w_head;
  cmd_t w_in;
  logic w_unused;

  // alu_busy is informational only
  assign w_unused = alu_busy;

  assign cmd_ready = (r_count != CNT_W'(DEPTH));
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_in      = '{op: cmd_op, a: cmd_a, b: cmd_b};

  // Completion class of the outstanding command (operands held in r_alu_*)
  assign w_mac_clr = (r_alu_op == OP_MAC) && (r_alu_a == '0) && (r_alu_b == '0);
  assign w_multi   = (r_alu_op == OP_MUL) || (r_alu_op == OP_EXP) ||
                     (r_alu_op == OP_DIV) || (r_alu_op == OP_MOD) ||
                     ((r_alu_op == OP_MAC) && !w_mac_clr);

  // FIFO storage; contents need no reset, the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Issue/complete/respond sequencer with registered ALU and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_alu_start   <= 1'b0;
      r_alu_op      <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_op      <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_alu_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_alu_op    <= w_head.op;
            r_alu_a     <= w_head.a;
            r_alu_b     <= w_head.b;
            r_alu_start <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          if (w_multi) begin
            if (alu_valid) begin
              r_rsp_result  <= alu_result;
              r_rsp_error   <= alu_error;
              r_rsp_timeout <= 1'b0;
              r_rsp_op      <= r_alu_op;
              r_rsp_valid   <= 1'b1;
              r_state       <= ST_RESP;
            end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
              r_rsp_result  <= '0;
              r_rsp_error   <= 1'b1;
              r_rsp_timeout <= 1'b1;
              r_rsp_op      <= r_alu_op;
              r_rsp_valid   <= 1'b1;
              r_state       <= ST_RESP;
            end
          end else if (r_wait_cnt == WAIT_W'(FIXED_LAT - 1)) begin
            r_rsp_result  <= w_mac_clr ? '0 : alu_result;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_op      <= r_alu_op;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_start   = r_alu_start;
  assign alu_op      = r_alu_op;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_op      = r_rsp_op;
  assign rsp_error   = r_rsp_error;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a reactive ALU model, a transaction-level
// reference model checked every cycle, directed scenarios and random traffic.
module tb_alu_cmd_sequencer;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned FIXED_LAT  = 2;
  localparam int unsigned TB_TIMEOUT = 40;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  int               cmd_lat;
  logic             alu_start;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_valid;
  logic             alu_busy;
  logic             alu_error;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [4:0]       rsp_op;
  logic             rsp_error;
  logic             rsp_timeout;

  alu_cmd_sequencer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FIXED_LAT(FIXED_LAT), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_valid(alu_valid), .alu_busy(alu_busy), .alu_error(alu_error),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_op(rsp_op), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;   // ALU completion delay after start; 0 = never
  } cmd_t;

  // ALU behaviour assumed by the bench
  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      5'd0:    return a & b;
      5'd8:    return a * b;
      5'd9:    return a ^ {b[15:0], b[31:16]};
      5'd10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd11:   return (b == 0) ? a : a % b;
      5'd14:   return a * b + 32'h55;
      default: return a + b + 32'(op);
    endcase
  endfunction

  function automatic bit alu_err(input logic [4:0] op, input logic [31:0] b);
    return (op == 5'd10 || op == 5'd11) && b == 0;
  endfunction

  function automatic bit is_multi(input logic [4:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    return (op >= 5'd8 && op <= 5'd11) || (op == 5'd14 && (a | b) != 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: pending queue, one outstanding command, response schedule
  cmd_t        q[$];
  cmd_t        out;
  bit          have_out = 0;
  bit          model_ok = 0;
  int          s_cyc, rsp_cyc, idle_from;
  int          fire = -1;
  logic [4:0]  e_alu_op, e_rop, p_rop;
  logic [31:0] e_alu_a, e_alu_b, e_res, p_res;
  logic        e_err, e_to, p_err, p_to;

  always @(negedge clk) begin : model_chk
    int k;
    int lat;
    bit full;
    k = cyc;
    if (model_ok) begin
      chk("cmd_ready", cmd_ready, q.size() != DEPTH);
      chk("alu_start", alu_start, have_out && k == s_cyc);
      chk("rsp_valid", rsp_valid, have_out && k >= rsp_cyc);
      chk("alu_op", alu_op, e_alu_op);
      chk("alu_a", alu_a, e_alu_a);
      chk("alu_b", alu_b, e_alu_b);
      chk("rsp_result", rsp_result, e_res);
      chk("rsp_op", rsp_op, e_rop);
      chk("rsp_error", rsp_error, e_err);
      chk("rsp_timeout", rsp_timeout, e_to);
    end
    // ALU model arms its completion when it sees the expected start
    if (alu_start && have_out && k == s_cyc && is_multi(out.op, out.a, out.b))
      fire = (out.lat == 0) ? -1 : k + out.lat;
    if (rst) begin
      q.delete();
      have_out = 0;
      idle_from = k + 1;
      fire = -1;
      e_alu_op = '0; e_alu_a = '0; e_alu_b = '0;
      e_res = '0; e_rop = '0; e_err = 1'b0; e_to = 1'b0;
      model_ok = 1;
    end else begin
      full = (q.size() == DEPTH);
      if (!have_out && k >= idle_from && q.size() > 0) begin
        out = q.pop_front();
        have_out = 1;
        s_cyc = k + 1;
        e_alu_op = out.op; e_alu_a = out.a; e_alu_b = out.b;
        p_rop = out.op;
        if (!is_multi(out.op, out.a, out.b)) begin
          lat = FIXED_LAT + 1;
          p_res = (out.op == 5'd14) ? 32'h0 : alu_f(out.op, out.a, out.b);
          p_err = 1'b0; p_to = 1'b0;
        end else if (out.lat >= 1 && out.lat <= int'(TB_TIMEOUT)) begin
          lat = out.lat + 1;
          p_res = alu_f(out.op, out.a, out.b);
          p_err = alu_err(out.op, out.b); p_to = 1'b0;
        end else begin
          lat = TB_TIMEOUT + 1;
          p_res = '0; p_err = 1'b1; p_to = 1'b1;
        end
        rsp_cyc = s_cyc + lat;
      end else if (have_out && k >= rsp_cyc && rsp_ready) begin
        have_out = 0;
        idle_from = k + 1;
      end
      if (cmd_valid && !full) q.push_back('{cmd_op, cmd_a, cmd_b, cmd_lat});
      if (have_out && rsp_cyc == k + 1) begin
        e_res = p_res; e_rop = p_rop; e_err = p_err; e_to = p_to;
      end
    end
  end

  // ALU model drive: completion pulse for multi-cycle ops, noise elsewhere
  always @(posedge clk) begin
    #1;
    alu_busy = 1'($urandom_range(0, 1));
    if (fire >= 0 && cyc == fire) begin
      alu_valid  = 1'b1;
      alu_result = alu_f(alu_op, alu_a, alu_b);
      alu_error  = alu_err(alu_op, alu_b);
    end else begin
      alu_error = 1'($urandom_range(0, 1));
      if (is_multi(alu_op, alu_a, alu_b)) begin
        alu_valid  = 1'b0;
        alu_result = $urandom;
      end else begin
        alu_valid  = ($urandom_range(0, 3) == 0);
        alu_result = alu_f(alu_op, alu_a, alu_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat);
    bit ok;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_lat = lat; cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
      if (ok) begin
        cmd_valid = 1'b0;
        return;
      end
    end
    cmd_valid = 1'b0;
    tests++; fails++;
    $display("FAIL push_accept cyc=%0d actual=not_accepted expected=accepted", cyc);
  endtask

  task automatic wait_rsp(output int n);
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    tests++; fails++;
    $display("FAIL rsp_wait cyc=%0d actual=no_rsp expected=rsp_valid", cyc);
  endtask

  task automatic rand_cmd();
    int l;
    cmd_op = ($urandom_range(0, 9) < 4) ? 5'(8 + $urandom_range(0, 3))
                                        : 5'($urandom_range(0, 31));
    if ($urandom_range(0, 9) == 0) cmd_op = 5'd14;
    cmd_a = $urandom; cmd_b = $urandom;
    if (cmd_op == 5'd14 && $urandom_range(0, 2) == 0) begin cmd_a = '0; cmd_b = '0; end
    if ((cmd_op == 5'd10 || cmd_op == 5'd11) && $urandom_range(0, 3) == 0) cmd_b = '0;
    l = $urandom_range(0, 19);
    cmd_lat = (l == 0) ? 0 : (l == 1) ? TB_TIMEOUT : (l == 2) ? TB_TIMEOUT + 1
                                                            : $urandom_range(1, 6);
    cmd_valid = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    int n, start_n, starts;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_lat = 0;
    alu_valid = 1'b0; alu_busy = 1'b0; alu_error = 1'b0; alu_result = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_rsp_result", rsp_result, 0);
    tick();

    // AND: start one cycle after acceptance, response four cycles after
    push_cmd(5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 0);
    start_n = -1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (alu_start && start_n < 0) start_n = n;
      if (rsp_valid) break;
    end
    chk("and_start_lat", 32'(start_n), 1);
    chk("and_rsp_lat", 32'(n), 4);
    chk("and_result", rsp_result, 32'hF000F000);
    chk("and_error", rsp_error, 0);
    tick();

    // DIV completes on alu_valid 33 cycles after start
    push_cmd(5'd10, 32'd100, 32'd7, 33);
    wait_rsp(n);
    chk("div_rsp_lat", 32'(n), 35);
    chk("div_result", rsp_result, 32'd14);
    chk("div_error", rsp_error, 0);
    tick();
    push_cmd(5'd10, 32'd100, 32'd0, 33);
    wait_rsp(n);
    chk("div0_error", rsp_error, 1);
    chk("div0_timeout", rsp_timeout, 0);
    tick();

    // Five commands while stalled: FIFO fills, responses come back in order
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(5'd1, 32'(i + 1), 32'd10, 0);
    @(negedge clk);
    chk("full_cmd_ready", cmd_ready, 0);
    tick();
    repeat (10) tick();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(n);
      chk("stall_order", rsp_result, 32'(12 + i));
      tick();
    end

    // EXP that never completes times out; the queued AND then issues normally
    push_cmd(5'd9, 32'd5, 32'd6, 0);
    push_cmd(5'd0, 32'hFFFF0000, 32'h0F0F0F0F, 0);
    wait_rsp(n);
    chk("to_rsp_lat", 32'(n), 32'(TB_TIMEOUT + 1));
    chk("to_result", rsp_result, 0);
    chk("to_error", rsp_error, 1);
    chk("to_timeout", rsp_timeout, 1);
    chk("to_op", rsp_op, 5'd9);
    tick();
    wait_rsp(n);
    chk("after_to_result", rsp_result, 32'h0F0F0000);
    chk("after_to_timeout", rsp_timeout, 0);
    tick();

    // MAC clear is fixed latency with result 0; real MAC waits for alu_valid
    push_cmd(5'd14, 32'd0, 32'd0, 0);
    push_cmd(5'd14, 32'd3, 32'd4, 6);
    wait_rsp(n);
    chk("macclr_lat", 32'(n), 3);
    chk("macclr_result", rsp_result, 0);
    tick();
    wait_rsp(n);
    chk("mac_result", rsp_result, 32'h61);
    tick();

    // Reset during WAIT with two queued commands discards everything
    push_cmd(5'd8, 32'd7, 32'd7, 0);
    push_cmd(5'd1, 32'd1, 32'd1, 0);
    push_cmd(5'd1, 32'd2, 32'd2, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    starts = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (alu_start) starts++;
    end
    chk("rst_mid_no_start", 32'(starts), 0);
    tick();

    // Random traffic against the reference model
    for (int i = 0; i < 2500; i++) begin
      rand_cmd();
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3000 && (have_out || q.size() != 0); i++) tick();
    repeat (2) tick();
    @(negedge clk);
    chk("drain_rsp_valid", rsp_valid, 0);
    chk("drain_cmd_ready", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
